// File: rtl/i2s_rx_stereo_if.sv
// I2S pins plus buffered read side of i2s_rx_stereo; irq/irq_thresh exist only with I2S_RX_IRQ_EN.
// master = the receiver (drives BCLK/WS and the read data), slave = the SoC side / external device.
interface i2s_rx_stereo_if #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              en;
  logic              BCLK;
  logic              WS;
  logic              DIN;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ch;
  logic              empty;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              ovf_clr;
`ifdef I2S_RX_IRQ_EN
  logic [LVL_W-1:0]  irq_thresh;
  logic              irq;

  modport master (
    input  en, DIN, rd_en, ovf_clr, irq_thresh,
    output BCLK, WS, rd_data, rd_ch, empty, level, overflow, irq
  );
  modport slave (
    output en, DIN, rd_en, ovf_clr, irq_thresh,
    input  BCLK, WS, rd_data, rd_ch, empty, level, overflow, irq
  );
`else
  modport master (
    input  en, DIN, rd_en, ovf_clr,
    output BCLK, WS, rd_data, rd_ch, empty, level, overflow
  );
  modport slave (
    output en, DIN, rd_en, ovf_clr,
    input  BCLK, WS, rd_data, rd_ch, empty, level, overflow
  );
`endif
endinterface

// File: rtl/i2s_rx_stereo.sv
// I2S master receiver: BCLK/WS generation, one-bit-delay capture, sign-extended stereo FIFO (FWFT).
// Push one clk after the last captured bit; a push into a full FIFO without a pop is dropped and flags overflow. Optional irq: I2S_RX_IRQ_EN.
module i2s_rx_stereo #(
  parameter int CLK_DIV    = 4,
  parameter int SLOT_W     = 32,
  parameter int SAMPLE_W   = 18,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  i2s_rx_stereo_if.master     bus
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(SLOT_W);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic              ch;
    logic [DATA_W-1:0] dat;
  } ent_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.en) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.en) begin
          w_run = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus clock generation; everything collapses to zero whenever we are not actively running.
  logic [DIV_W-1:0] r_div;
  logic             r_bclk;
  logic             r_ws;
  logic [BIT_W-1:0] r_bit;
  logic             w_tick;
  logic             w_rise;
  logic             w_fall;

  assign w_tick = w_run && (r_div == DIV_W'(CLK_DIV - 1));
  assign w_rise = w_tick && !r_bclk;
  assign w_fall = w_tick && r_bclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
      r_ws   <= 1'b0;
      r_bit  <= '0;
    end else if (!w_run) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
      r_ws   <= 1'b0;
      r_bit  <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_bclk <= ~r_bclk;
      end
      if (w_fall) begin
        if (r_bit == BIT_W'(SLOT_W - 1)) begin
          r_bit <= '0;
          r_ws  <= ~r_ws;
        end else begin
          r_bit <= r_bit + 1'b1;
        end
      end
    end
  end

  // Slot bit 0 carries the previous slot's LSB, so the sample occupies bits 1..SAMPLE_W.
  logic [SAMPLE_W-1:0] r_shift;
  logic                r_push;
  logic                r_push_ch;
  logic                w_cap;
  logic [DATA_W-1:0]   w_ext;

  assign w_cap = w_rise && (r_bit != '0) && (r_bit <= BIT_W'(SAMPLE_W));
  assign w_ext = DATA_W'($signed(r_shift));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_push    <= 1'b0;
      r_push_ch <= 1'b0;
    end else begin
      r_push <= w_rise && (r_bit == BIT_W'(SAMPLE_W));
      if (w_rise) begin
        r_push_ch <= r_ws;
      end
      if (!w_run) begin
        r_shift <= '0;
      end else if (w_cap) begin
        r_shift <= SAMPLE_W'({r_shift, bus.DIN});
      end
    end
  end

  ent_t             r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             r_ovf;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;
  logic             w_drop;

  assign w_full = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop  = bus.rd_en && (r_level != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_wr   = r_push && (!w_full || w_pop);
  assign w_drop = r_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[r_wptr] <= '{ch: r_push_ch, dat: w_ext};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.BCLK     = r_bclk;
  assign bus.WS       = r_ws;
  assign bus.rd_data  = r_mem[r_rptr].dat;
  assign bus.rd_ch    = r_mem[r_rptr].ch;
  assign bus.empty    = (r_level == '0);
  assign bus.level    = r_level;
  assign bus.overflow = r_ovf;

`ifdef I2S_RX_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= ((r_level >= bus.irq_thresh) && (bus.irq_thresh != '0)) || r_ovf;
    end
  end

  assign bus.irq = r_irq;
`endif

endmodule
